// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared types and select encoding for the round-robin mux arbiter.
package mux_arb_pkg;
    typedef enum logic [1:0] {GNT_A, GNT_B, GNT_C} grant_e;
    typedef enum logic {IDLE, GRANT} state_e;

    // Returns {sel_2, sel_1} steering the two-level datapath to the granted input.
    function automatic logic [1:0] sel_of(grant_e g);
        return (g == GNT_B) ? 2'b01 : (g == GNT_C) ? 2'b10 : 2'b00;
    endfunction
endpackage

// File: rtl/mux_share_arbiter_dp.sv
// mux3_sel_dp: two-level select, sel_1 picks a/b, sel_2 picks that result or c.
module mux3_sel_dp #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    input  logic              sel_1,
    input  logic              sel_2,
    output logic [DATA_W-1:0] y
);
    logic [DATA_W-1:0] w_l1;
    assign w_l1 = sel_1 ? b : a;
    assign y    = sel_2 ? c : w_l1;
endmodule

// File: rtl/mux_share_arbiter.sv
// mux_share_arbiter: round-robin burst arbiter sharing the 3-input select datapath
// between three valid/ready requesters onto one output stream.
module mux_share_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          req_valid,
    input  logic [2:0]          req_last,
    input  logic [3*DATA_W-1:0] req_data,
    output logic [2:0]          req_ready,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    input  logic                out_ready,
    output logic                sel_1,
    output logic                sel_2,
    output logic                busy
);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] LAST_BEAT = HW'(MAX_HOLD - 1);

    state_e        r_state, w_state_nx;
    grant_e        r_grant, w_grant_nx;
    logic [HW-1:0] r_hold, w_hold_nx;
    logic [1:0]    w_cand;
    logic          w_found, w_busy, w_gv, w_xfer, w_release;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= GNT_C;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_grant <= w_grant_nx;
            r_hold  <= w_hold_nx;
        end
    end

    assign w_busy    = (r_state == GRANT);
    assign w_gv      = req_valid[r_grant];
    assign w_xfer    = w_busy & w_gv & out_ready;
    assign w_release = w_busy & (~w_gv | (w_xfer & (req_last[r_grant] | (r_hold == LAST_BEAT))));

    // Circular search starts just after the previous grant, so it loses priority.
    always_comb begin
        w_state_nx = r_state;
        w_grant_nx = r_grant;
        w_hold_nx  = r_hold;
        w_cand     = r_grant;
        w_found    = 1'b0;
        if (!w_busy) begin
            for (int k = 0; k < 3; k++) begin
                w_cand = (w_cand == 2'd2) ? 2'd0 : w_cand + 2'd1;
                if (!w_found && req_valid[w_cand]) begin
                    w_found    = 1'b1;
                    w_grant_nx = grant_e'(w_cand);
                end
            end
            if (w_found) begin
                w_state_nx = GRANT;
                w_hold_nx  = '0;
            end
        end else if (w_release) begin
            w_state_nx = IDLE;
        end else if (w_xfer) begin
            w_hold_nx = r_hold + HW'(1);
        end
    end

    // Handshake is masked while rst is high so no beat completes in the reset cycle.
    assign {sel_2, sel_1} = w_busy ? sel_of(r_grant) : 2'b00;
    assign out_valid      = w_busy & w_gv & ~rst;
    assign req_ready      = (w_busy & out_ready & ~rst) ? (3'b001 << r_grant) : 3'b000;
    assign busy           = w_busy;

    mux3_sel_dp #(.DATA_W(DATA_W)) u_dp (
        .a     (req_data[0*DATA_W +: DATA_W]),
        .b     (req_data[1*DATA_W +: DATA_W]),
        .c     (req_data[2*DATA_W +: DATA_W]),
        .sel_1 (sel_1),
        .sel_2 (sel_2),
        .y     (out_data)
    );
endmodule
